// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC fetch controller: FSM states,
// PC increment and redirect priority ranking.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_ISSUE,
        ST_STALL
    } fetch_state_e;

    localparam int unsigned PC_INC = 4;

    // Numeric order is the priority order; a larger value wins.
    typedef enum logic [1:0] {
        PRIO_NONE = 2'd0,
        PRIO_BR   = 2'd1,
        PRIO_JMP  = 2'd2,
        PRIO_EXC  = 2'd3
    } redir_prio_e;

endpackage

// File: rtl/pc_redirect_mux.sv
// Combinational next-PC selection: exc > jmp > branch > pending > pc+4.
// Define PC_FETCH_ALIGN_CHK_EN to trap misaligned jmp/branch targets to EXC_VEC.
module pc_redirect_mux
    import pc_fetch_pkg::*;
#(
    parameter int unsigned     B       = 32,
    parameter logic [B-1:0]    EXC_VEC = 32'h8000_0180
) (
    input  logic        exc,
    input  logic        jmp,
    input  logic [B-1:0] jmp_target,
    input  logic        br_taken,
    input  logic [B-1:0] br_target,
    input  redir_prio_e pend_prio,
    input  logic [B-1:0] pend_target,
    input  logic [B-1:0] pc_cur,
    output redir_prio_e redir_prio,
    output logic [B-1:0] redir_target,
    output logic [B-1:0] next_pc,
    output logic        align_err
);

`ifdef PC_FETCH_ALIGN_CHK_EN
    logic misaligned;
`endif

    always_comb begin
        redir_prio   = PRIO_NONE;
        redir_target = '0;
        align_err    = 1'b0;
`ifdef PC_FETCH_ALIGN_CHK_EN
        misaligned   = 1'b0;
`endif
        if (exc) begin
            redir_prio   = PRIO_EXC;
            redir_target = EXC_VEC;
        end else if (jmp) begin
            redir_prio   = PRIO_JMP;
            redir_target = jmp_target;
`ifdef PC_FETCH_ALIGN_CHK_EN
            misaligned   = |jmp_target[1:0];
`endif
        end else if (br_taken) begin
            redir_prio   = PRIO_BR;
            redir_target = br_target;
`ifdef PC_FETCH_ALIGN_CHK_EN
            misaligned   = |br_target[1:0];
`endif
        end

`ifdef PC_FETCH_ALIGN_CHK_EN
        if (misaligned) begin
            redir_target = EXC_VEC;
            align_err    = 1'b1;
        end
`endif

        if (redir_prio != PRIO_NONE) begin
            next_pc = redir_target;
        end else if (pend_prio != PRIO_NONE) begin
            next_pc = pend_target;
        end else begin
            next_pc = pc_cur + B'(PC_INC);
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer driving an external PC register and instruction memory.
// Optional PC_FETCH_ALIGN_CHK_EN enables misaligned-target trapping in the mux.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter int unsigned  B         = 32,
    parameter logic [B-1:0] RESET_VEC = 32'h0040_0000,
    parameter logic [B-1:0] EXC_VEC   = 32'h8000_0180
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [B-1:0] pc_cur,
    output logic [B-1:0] pc_next,
    output logic         pc_load,
    output logic         imem_req,
    output logic [B-1:0] imem_addr,
    input  logic         imem_ack,
    output logic         instr_valid,
    input  logic         stall,
    input  logic         br_taken,
    input  logic [B-1:0] br_target,
    input  logic         jmp,
    input  logic [B-1:0] jmp_target,
    input  logic         exc,
    output logic         align_err
);

    fetch_state_e state_q, state_d;
    redir_prio_e  pend_prio_q, pend_prio_d;
    logic [B-1:0] pend_tgt_q, pend_tgt_d;

    redir_prio_e  redir_prio;
    logic [B-1:0] redir_target;
    logic [B-1:0] mux_next;
    logic         mux_align_err;

    pc_redirect_mux #(
        .B       (B),
        .EXC_VEC (EXC_VEC)
    ) u_mux (
        .exc          (exc),
        .jmp          (jmp),
        .jmp_target   (jmp_target),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .pend_prio    (pend_prio_q),
        .pend_target  (pend_tgt_q),
        .pc_cur       (pc_cur),
        .redir_prio   (redir_prio),
        .redir_target (redir_target),
        .next_pc      (mux_next),
        .align_err    (mux_align_err)
    );

    // Outputs react to ack/redirects in the same cycle, so they are combinational;
    // gating with rst_n keeps them at zero for the whole reset assertion.
    always_comb begin
        state_d     = state_q;
        pend_prio_d = pend_prio_q;
        pend_tgt_d  = pend_tgt_q;
        pc_load     = 1'b0;
        pc_next     = '0;
        imem_req    = 1'b0;
        imem_addr   = '0;
        instr_valid = 1'b0;
        align_err   = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                ST_BOOT: begin
                    pc_load = 1'b1;
                    pc_next = RESET_VEC;
                    state_d = ST_ISSUE;
                end
                ST_ISSUE: begin
                    imem_req  = 1'b1;
                    imem_addr = pc_cur;
                    align_err = mux_align_err;
                    if (imem_ack) begin
                        pc_load     = 1'b1;
                        pc_next     = mux_next;
                        instr_valid = (redir_prio == PRIO_NONE) && (pend_prio_q == PRIO_NONE);
                        pend_prio_d = PRIO_NONE;
                        state_d     = stall ? ST_STALL : ST_ISSUE;
                    end else if ((redir_prio != PRIO_NONE) && (redir_prio >= pend_prio_q)) begin
                        pend_prio_d = redir_prio;
                        pend_tgt_d  = redir_target;
                    end
                end
                ST_STALL: begin
                    align_err = mux_align_err;
                    if (redir_prio != PRIO_NONE) begin
                        pc_load     = 1'b1;
                        pc_next     = redir_target;
                        pend_prio_d = PRIO_NONE;
                    end
                    if (!stall) begin
                        state_d = ST_ISSUE;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            pend_prio_q <= PRIO_NONE;
            pend_tgt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pend_prio_q <= pend_prio_d;
            pend_tgt_q  <= pend_tgt_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios then random traffic
// compared against a cycle-level behavioural model of the fetch rules.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0040_0000;
    localparam logic [31:0] EV = 32'h8000_0180;
`ifdef PC_FETCH_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_cur, pc_next, imem_addr;
    logic [31:0] br_target = '0, jmp_target = '0;
    logic        pc_load, imem_req, instr_valid, align_err;
    logic        imem_ack = 1'b0, stall = 1'b0, br_taken = 1'b0, jmp = 1'b0, exc = 1'b0;

    int checks = 0;
    int errors = 0;

    // External PC register (environment) and reference-model state.
    logic [31:0] pc_reg = '0;
    bit          m_boot = 1'b1;
    bit          m_stalled = 1'b0;
    int          m_pend = 0;
    logic [31:0] m_pend_tgt = '0;

    assign pc_cur = pc_reg;
    always #5 clk = ~clk;

    pc_fetch_ctrl #(
        .B         (32),
        .RESET_VEC (RV),
        .EXC_VEC   (EV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_cur      (pc_cur),
        .pc_next     (pc_next),
        .pc_load     (pc_load),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .instr_valid (instr_valid),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp         (jmp),
        .jmp_target  (jmp_target),
        .exc         (exc),
        .align_err   (align_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Redirect present this cycle: rank 3=exc, 2=jmp, 1=branch, 0=none.
    function automatic void present(output int r, output logic [31:0] t, output bit bad);
        r = 0; t = '0; bad = 1'b0;
        if (exc)           begin r = 3; t = EV;         end
        else if (jmp)      begin r = 2; t = jmp_target; end
        else if (br_taken) begin r = 1; t = br_target;  end
        if (ALIGN_CHK && (r == 1 || r == 2) && (t[1:0] != 2'b00)) begin
            t = EV; bad = 1'b1;
        end
    endfunction

    task automatic idle();
        imem_ack = 1'b0; stall = 1'b0; br_taken = 1'b0; jmp = 1'b0; exc = 1'b0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance both.
    task automatic tick();
        int r; logic [31:0] t; bit bad;
        logic e_load, e_req, e_valid, e_aerr;
        logic [31:0] e_next, e_addr, s_next;
        logic s_load;
        #2;
        present(r, t, bad);
        e_load = 0; e_req = 0; e_valid = 0; e_aerr = 0; e_next = '0; e_addr = '0;
        if (rst_n) begin
            if (m_boot) begin
                e_load = 1; e_next = RV;
            end else if (!m_stalled) begin
                e_req = 1; e_addr = pc_cur; e_aerr = bad;
                if (imem_ack) begin
                    e_load  = 1;
                    e_next  = (r != 0) ? t : (m_pend != 0) ? m_pend_tgt : pc_cur + 32'd4;
                    e_valid = (r == 0) && (m_pend == 0);
                end
            end else begin
                e_aerr = bad;
                if (r != 0) begin e_load = 1; e_next = t; end
            end
        end
        check_eq("pc_load", 32'(pc_load), 32'(e_load));
        check_eq("pc_next", pc_next, e_next);
        check_eq("imem_req", 32'(imem_req), 32'(e_req));
        check_eq("imem_addr", imem_addr, e_addr);
        check_eq("instr_valid", 32'(instr_valid), 32'(e_valid));
        check_eq("align_err", 32'(align_err), 32'(e_aerr));
        s_load = pc_load; s_next = pc_next;
        @(posedge clk);
        if (!rst_n) begin
            m_boot = 1; m_stalled = 0; m_pend = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (!m_stalled) begin
            if (imem_ack) begin
                m_pend = 0; m_stalled = stall;
            end else if (r != 0 && r >= m_pend) begin
                m_pend = r; m_pend_tgt = t;
            end
        end else begin
            if (r != 0) m_pend = 0;
            if (!stall) m_stalled = 0;
        end
        if (s_load) pc_reg = s_next;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        @(negedge clk);
        tick(); tick();

        // Boot then three back-to-back fetches.
        rst_n = 1'b1; imem_ack = 1'b1;
        #1; check_eq("boot_load", 32'(pc_load), 32'd1); check_eq("boot_vec", pc_next, RV);
        tick();
        for (int k = 0; k < 3; k++) begin
            #1; check_eq("seq_addr", imem_addr, RV + 32'(4 * k));
            check_eq("seq_valid", 32'(instr_valid), 32'd1);
            tick();
        end

        // Branch captured two cycles ahead of a delayed ack.
        idle(); br_taken = 1'b1; br_target = 32'h0040_0100; tick();
        idle(); tick();
        imem_ack = 1'b1;
        #1; check_eq("br_valid", 32'(instr_valid), 32'd0); check_eq("br_next", pc_next, 32'h0040_0100);
        tick();
        idle();
        #1; check_eq("br_addr", imem_addr, 32'h0040_0100);
        tick();

        // exc beats jmp.
        imem_ack = 1'b1; exc = 1'b1; jmp = 1'b1; jmp_target = 32'h0040_0200;
        #1; check_eq("exc_prio", pc_next, EV);
        tick();

        // Stall at ack, jump during the stall, resume at jump target.
        idle(); pc_reg = 32'h0040_0010;
        imem_ack = 1'b1; stall = 1'b1;
        #1; check_eq("stall_next", pc_next, 32'h0040_0014);
        tick();
        imem_ack = 1'b0;
        #1; check_eq("stall_req", 32'(imem_req), 32'd0);
        tick();
        jmp = 1'b1; jmp_target = 32'h0040_0300;
        #1; check_eq("stall_jload", 32'(pc_load), 32'd1); check_eq("stall_jnext", pc_next, 32'h0040_0300);
        tick();
        idle(); tick();
        #1; check_eq("resume_addr", imem_addr, 32'h0040_0300);
        tick();

        // PC wraparound.
        pc_reg = 32'hFFFF_FFFC; imem_ack = 1'b1;
        #1; check_eq("wrap_next", pc_next, 32'h0000_0000);
        tick();

        // Misaligned jump target.
        imem_ack = 1'b1; jmp = 1'b1; jmp_target = 32'h0040_0202;
        #1;
        check_eq("align_next", pc_next, ALIGN_CHK ? EV : 32'h0040_0202);
        check_eq("align_flag", 32'(align_err), ALIGN_CHK ? 32'd1 : 32'd0);
        tick();

        // Reset during an outstanding fetch.
        idle(); tick();
        rst_n = 1'b0;
        #1; check_eq("rst_req", 32'(imem_req), 32'd0);
        tick();
        rst_n = 1'b1;
        #1; check_eq("rst_boot", pc_next, RV); check_eq("rst_boot_req", 32'(imem_req), 32'd0);
        tick();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            imem_ack   = ($urandom_range(0, 1) == 1);
            stall      = ($urandom_range(0, 9) < 3);
            exc        = ($urandom_range(0, 19) == 0);
            jmp        = ($urandom_range(0, 9) == 0);
            br_taken   = ($urandom_range(0, 9) == 0);
            jmp_target = $urandom & ~32'd3;
            br_target  = $urandom & ~32'd3;
            if ($urandom_range(0, 7) == 0) jmp_target[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) br_target[1:0]  = 2'($urandom_range(1, 3));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
